// File: rtl/crush_scheduler.sv
// Time-multiplexed bit-crush scheduler: sample-clock event -> level -> 3 shared-mask passes -> frame commit.
// Define CRUSH_HYST_EN to add a hysteresis band of HYST counts around the level thresholds.
module crush_scheduler #(
    parameter int W      = 16,
    parameter int HOLD_W = 4,
    parameter int HYST   = 400
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clk,
    input  logic signed [W-1:0] sample_in0,
    input  logic signed [W-1:0] sample_in1,
    input  logic signed [W-1:0] sample_in2,
    input  logic signed [W-1:0] sample_in3,
    input  logic [HOLD_W-1:0]   hold,
    output logic signed [W-1:0] sample_out0,
    output logic signed [W-1:0] sample_out1,
    output logic signed [W-1:0] sample_out2,
    output logic signed [W-1:0] sample_out3,
    output logic [3:0]          level,
    output logic                busy,
    output logic                overrun
);

    typedef enum logic [2:0] {IDLE, LEVEL, CH1, CH2, CH3, COMMIT} state_t;

    state_t              state_q, state_d;
    logic [2:0]          sync_q, sync_d;
    logic [3:0][W-1:0]   snap_q, snap_d;
    logic [2:0][W-1:0]   stg_q, stg_d;
    logic [3:0][W-1:0]   out_q, out_d;
    logic [3:0]          level_q, level_d;
    logic [HOLD_W-1:0]   dec_q, dec_d;
    logic                overrun_q, overrun_d;

    logic                evt;
    logic signed [31:0]  cv;
    logic [3:0]          raw, lvl_next;
    logic [W-1:0]        mask, operand, crushed;

    // sync_q[2] holds the previous synchronised value for edge detection
    assign evt = sync_q[1] & ~sync_q[2];
    assign cv  = {{(32-W){snap_q[0][W-1]}}, snap_q[0]};

    always_comb begin
        raw = '0;
        for (int k = 1; k <= 10; k++) begin
            if (cv > 2000 * k) raw = raw + 4'd1;
        end
    end

`ifdef CRUSH_HYST_EN
    always_comb begin
        lvl_next = level_q;
        if (raw > level_q) begin
            if (cv > 2000 * int'(raw) + HYST) lvl_next = raw;
        end else if (raw < level_q) begin
            if (cv <= 2000 * (int'(raw) + 1) - HYST) lvl_next = raw;
        end
    end
`else
    assign lvl_next = raw;
`endif

    // One mask/AND unit shared by the three audio channels, selected by state
    always_comb begin
        mask = (level_q >= 4'd10) ? {W{1'b1}} : ~({W{1'b1}} >> (32'(level_q) + 2));
        case (state_q)
            CH1:     operand = snap_q[1];
            CH2:     operand = snap_q[2];
            CH3:     operand = snap_q[3];
            default: operand = '0;
        endcase
        crushed = operand & mask;
    end

    always_comb begin
        state_d   = state_q;
        sync_d    = {sync_q[1:0], sample_clk};
        snap_d    = snap_q;
        stg_d     = stg_q;
        out_d     = out_q;
        level_d   = level_q;
        dec_d     = dec_q;
        overrun_d = evt && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (evt) begin
                    snap_d  = {sample_in3, sample_in2, sample_in1, sample_in0};
                    state_d = LEVEL;
                end
            end
            LEVEL: begin
                level_d = lvl_next;
                state_d = CH1;
            end
            CH1: begin
                stg_d[0] = crushed;
                state_d  = CH2;
            end
            CH2: begin
                stg_d[1] = crushed;
                state_d  = CH3;
            end
            CH3: begin
                stg_d[2] = crushed;
                state_d  = COMMIT;
            end
            COMMIT: begin
                out_d[0] = snap_q[0];
                if (dec_q == '0) out_d[3:1] = stg_q;
                // >= so a hold reduced below the running count wraps immediately
                dec_d   = (dec_q >= hold) ? '0 : dec_q + HOLD_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            snap_q    <= '0;
            stg_q     <= '0;
            out_q     <= '0;
            level_q   <= '0;
            dec_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            snap_q    <= snap_d;
            stg_q     <= stg_d;
            out_q     <= out_d;
            level_q   <= level_d;
            dec_q     <= dec_d;
            overrun_q <= overrun_d;
        end
    end

    assign sample_out0 = out_q[0];
    assign sample_out1 = out_q[1];
    assign sample_out2 = out_q[2];
    assign sample_out3 = out_q[3];
    assign level       = level_q;
    assign busy        = (state_q != IDLE);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_crush_scheduler.sv
// Bench for crush_scheduler: directed plan cases plus random frames against a frame-level reference model.
module tb_crush_scheduler;

    localparam int HYST = 400;

    logic               clk = 1'b0;
    logic               rst;
    logic               sample_clk;
    logic signed [15:0] in0, in1, in2, in3;
    logic [3:0]         hold;
    logic signed [15:0] out0, out1, out2, out3;
    logic [3:0]         level;
    logic               busy, overrun;

    int checks = 0;
    int errors = 0;

    int                 ref_level, ref_dec;
    logic signed [15:0] ref_out [4];

    crush_scheduler #(.W(16), .HOLD_W(4), .HYST(HYST)) dut (
        .clk(clk), .rst(rst), .sample_clk(sample_clk),
        .sample_in0(in0), .sample_in1(in1), .sample_in2(in2), .sample_in3(in3),
        .hold(hold),
        .sample_out0(out0), .sample_out1(out1), .sample_out2(out2), .sample_out3(out3),
        .level(level), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        ref_level = 0;
        ref_dec   = 0;
        for (int i = 0; i < 4; i++) ref_out[i] = '0;
    endtask

    // Whole-frame effect of one accepted event
    task automatic model_event(input logic signed [15:0] a0, a1, a2, a3, input int h);
        int raw;
        logic [15:0] m;
        raw = 0;
        for (int k = 1; k <= 10; k++) if (int'(a0) > 2000 * k) raw++;
`ifdef CRUSH_HYST_EN
        if (raw > ref_level && int'(a0) > 2000 * raw + HYST) ref_level = raw;
        else if (raw < ref_level && int'(a0) <= 2000 * (raw + 1) - HYST) ref_level = raw;
`else
        ref_level = raw;
`endif
        m = (ref_level == 10) ? 16'hFFFF : (16'hFFFF << (14 - ref_level));
        ref_out[0] = a0;
        if (ref_dec == 0) begin
            ref_out[1] = a1 & m;
            ref_out[2] = a2 & m;
            ref_out[3] = a3 & m;
        end
        ref_dec = (ref_dec >= h) ? 0 : ref_dec + 1;
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, ".out0"}, out0, ref_out[0]);
        chk({tag, ".out1"}, out1, ref_out[1]);
        chk({tag, ".out2"}, out2, ref_out[2]);
        chk({tag, ".out3"}, out3, ref_out[3]);
        chk({tag, ".level"}, level, ref_level);
    endtask

    // One clean frame: checks busy window, pre-commit outputs and post-commit outputs
    task automatic fire(input string tag, input logic signed [15:0] a0, a1, a2, a3, input logic [3:0] h);
        int ovr;
        ovr = 0;
        @(negedge clk);
        in0 = a0; in1 = a1; in2 = a2; in3 = a3; hold = h;
        sample_clk = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (overrun) ovr++;
            if (i == 3) chk({tag, ".busy_start"}, busy, 1'b1);
            if (i == 7) begin
                chk({tag, ".busy_end"}, busy, 1'b1);
                chk({tag, ".out1_early"}, out1, ref_out[1]);
                chk({tag, ".out0_early"}, out0, ref_out[0]);
            end
        end
        model_event(a0, a1, a2, a3, int'(h));
        chk_outs(tag);
        chk({tag, ".idle"}, busy, 1'b0);
        chk({tag, ".no_overrun"}, ovr, 0);
        @(negedge clk);
        sample_clk = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int ovr;
        logic signed [15:0] r0, r1, r2, r3;

        rst = 1'b1; sample_clk = 1'b0; hold = '0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        model_reset();
        repeat (3) @(posedge clk); #1;
        chk_outs("rst");
        chk("rst.busy", busy, 1'b0);
        chk("rst.overrun", overrun, 1'b0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);

        // Mask sweep
        fire("mask_l0",  16'sd0,     16'sh7FFF, 16'sd0, 16'sd0, 4'd0);
        fire("mask_l5",  16'sd10001, 16'sh7FFF, 16'sd0, 16'sd0, 4'd0);
        fire("mask_l10", 16'sd20001, 16'sh7FFF, 16'sd0, 16'sd0, 4'd0);
        chk("mask_l10.lit", out1, 32'hFFFF_7FFF & 32'h0000_7FFF);
        fire("mask_neg", 16'sd0,     -16'sd1,   16'sd0, 16'sd0, 4'd0);
        chk("mask_neg.lit", out1, 32'hFFFF_C000);

        // Shared unit coherence
        fire("coh", 16'sd8001, 16'sh1234, 16'sh5678, -16'sd300, 4'd0);
        chk("coh.lit1", out1, 32'h0000_1000);
        chk("coh.lit3", out3, 32'hFFFF_FC00);

        // Decimation with hold=2
        fire("dec1", 16'sd20001, 16'sh7000, 16'sd1, 16'sd2, 4'd2);
        fire("dec2", 16'sd20002, 16'sh6000, 16'sd3, 16'sd4, 4'd2);
        fire("dec3", 16'sd20003, 16'sh5000, 16'sd5, 16'sd6, 4'd2);
        fire("dec4", 16'sd20004, 16'sh4000, 16'sd7, 16'sd8, 4'd2);
        chk("dec4.lit", out1, 32'h0000_4000);

        // Overrun: second edge synchronised 3 clk after the first
        fire("pre_ovr", 16'sd0, 16'sd0, 16'sd0, 16'sd0, 4'd0);
        ovr = 0;
        @(negedge clk);
        in0 = 16'sd6001; in1 = 16'sh1357; in2 = 16'sh2468; in3 = -16'sd1000; sample_clk = 1'b1;
        @(posedge clk); #1; if (overrun) ovr++;
        @(negedge clk); sample_clk = 1'b0;
        @(posedge clk); #1; if (overrun) ovr++;
        @(posedge clk); #1; if (overrun) ovr++;
        @(negedge clk);
        in0 = 16'sd18000; in1 = 16'sh7777; in2 = 16'sh6666; in3 = 16'sh5555; sample_clk = 1'b1;
        for (int i = 4; i <= 16; i++) begin
            @(posedge clk); #1;
            if (overrun) ovr++;
        end
        model_event(16'sd6001, 16'sh1357, 16'sh2468, -16'sd1000, 0);
        chk_outs("ovr");
        chk("ovr.pulses", ovr, 1);
        chk("ovr.idle", busy, 1'b0);
        @(negedge clk); sample_clk = 1'b0;
        repeat (3) @(posedge clk);

        // Hysteresis walk (model picks the build-appropriate answer)
        fire("hy0", 16'sd0,    16'sh7FFF, 16'sd0, 16'sd0, 4'd0);
        fire("hy1", 16'sd2500, 16'sh7FFF, 16'sd0, 16'sd0, 4'd0);
        fire("hy2", 16'sd4100, 16'sh7FFF, 16'sd0, 16'sd0, 4'd0);
`ifdef CRUSH_HYST_EN
        chk("hy2.lit", level, 4'd1);
`else
        chk("hy2.lit", level, 4'd2);
`endif
        fire("hy3", 16'sd4500, 16'sh7FFF, 16'sd0, 16'sd0, 4'd0);
        fire("hy4", 16'sd3800, 16'sh7FFF, 16'sd0, 16'sd0, 4'd0);
        fire("hy5", 16'sd3500, 16'sh7FFF, 16'sd0, 16'sd0, 4'd0);

        // Reset mid-CH2 aborts the frame
        @(negedge clk);
        in0 = 16'sd15000; in1 = 16'sh7ABC; in2 = 16'sh1111; in3 = 16'sh2222; sample_clk = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("mid.busy", busy, 1'b1);
        rst = 1'b1; sample_clk = 1'b0;
        #1;
        model_reset();
        chk_outs("mid_rst");
        chk("mid_rst.busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk_outs("post_rst");
        chk("post_rst.busy", busy, 1'b0);
        fire("after_rst", 16'sd12345, 16'sh0F0F, -16'sd2, 16'sh7F00, 4'd0);

        // Random frames, including hold changes
        for (int n = 0; n < 40; n++) begin
            r0 = 16'($signed($urandom_range(0, 24000)) - 2000);
            r1 = 16'($urandom); r2 = 16'($urandom); r3 = 16'($urandom);
            fire("rnd", r0, r1, r2, r3, 4'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
